fpga_program_runner: RTL
========================

Name: fpga_program_runner

Overview:
- Parametrised successor to the single-instruction-pointer FPGA test harness.
- Holds a small loadable program memory and a register file. Executes a minimal integer ISA (MOV/ADD/SUB/JMP/JNZ/HALT) under its own instruction pointer.
- Reports completion, step count, fault and timeout status so FPGA test programs such as Add can be run and checked on hardware.

Parameters:
- DATA_WIDTH, 16: register and immediate width in bits.
- NREGS, 8: register-file depth (power of 2, ≥2). RW = log2(NREGS).
- PROG_DEPTH, 16: program-memory depth (power of 2). PW = log2(PROG_DEPTH).
- MAX_STEPS, 255: instruction budget per run. Counter width is SW = clog2(MAX_STEPS+1).

Ports:
- clock, input, 1: sole clock. All state changes on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- load, input, 1: write load_data into program[load_addr]. Honoured only in IDLE or DONE.
- load_addr, input, PW: program write address.
- load_data, input, 3+3*RW+DATA_WIDTH: instruction word {op[2:0], d, a, b, imm}, op in the MSBs.
- start, input, 1: begin a run at ip=0. Honoured only in IDLE or DONE.
- rd_addr, input, RW: register read-back address.
- rd_data, output, DATA_WIDTH: registered value of reg[rd_addr], one-cycle latency.
- busy, output, 1: high in FETCH or EXEC.
- done, output, 1: high in DONE.
- fault, output, 1: run ended by a reserved opcode or by ip running off the end of memory.
- timeout, output, 1: run ended because MAX_STEPS instructions executed without HALT.
- ip, output, PW: current instruction pointer.
- steps, output, SW: instructions executed in the current or last run.

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE.
  - ip, steps, rd_data, busy, done, fault and timeout are all 0.
  - All registers are 0.
  - Program memory is not reset; it keeps its contents.
- States: IDLE, FETCH, EXEC, DONE.
  - IDLE or DONE with start=1: go to FETCH. Clear ip, steps, fault, timeout and done. Registers are not cleared.
  - FETCH: latch program[ip] into the instruction register, then go to EXEC. Each instruction takes 2 cycles.
  - EXEC: execute the instruction and increment steps, then apply the first matching rule:
    1. HALT: go to DONE.
    2. Reserved op: set fault, go to DONE.
    3. steps reaches MAX_STEPS: set timeout, go to DONE.
    4. Next ip would be ≥ PROG_DEPTH: set fault, go to DONE.
    5. Otherwise go to FETCH.
- Opcodes (next ip is ip+1 unless stated):
  - 0 NOP.
  - 1 MOV: r[d]=imm.
  - 2 ADD: r[d]=r[a]+r[b], modulo 2^DATA_WIDTH. No carry out.
  - 3 SUB: r[d]=r[a]-r[b], modulo 2^DATA_WIDTH.
  - 4 JMP: ip=imm[PW-1:0].
  - 5 JNZ: if r[a]≠0 then ip=imm[PW-1:0], else ip+1.
  - 6 HALT.
  - 7 reserved (fault).
- Register r0:
  - Always reads 0.
  - Writes to r0 are discarded.
- Jumps:
  - A jump target is always in range, because it is truncated to PW bits.
  - A jump never causes the run-off-end fault.
- On a HALT, the instruction counts in steps. On a fault, the faulting instruction also counts.
- Timing:
  - The cycle in which start is sampled is cycle 0.
  - A run of N executed instructions asserts done at cycle 2N+1.
- Loading and start during a run:
  - load and start are ignored while busy.
  - If load and start are both asserted in the same honoured cycle, the write completes and the run starts. The first fetch, one cycle later, sees the new word.
- Read-back: rd_data is updated every cycle, including while busy. It reflects the register file state at the previous edge.
- Reset mid-run: abort immediately to IDLE with the reset values above.

Test Plan:
- Load {MOV r1,3; MOV r2,4; ADD r3,r1,r2; HALT}, pulse start → done at cycle 9, steps=4, rd r3=7, fault=0, timeout=0.
- Load {MOV r1,0xFFFF; MOV r2,1; ADD r3,r1,r2; MOV r0,5; HALT} → r3=0x0000, r0 reads 0, steps=5.
- Load {MOV r1,3; MOV r2,1; SUB r1,r1,r2; JNZ r1,2; HALT} → steps=9, r1=0, done at cycle 19.
- Load {JMP 0} with MAX_STEPS=255 → timeout=1, fault=0, steps=255, done at cycle 511.
- All 16 words NOP → fault=1, steps=16, ip=15.
- Load word with op=7 at addr 0 → fault=1, steps=1.
- Assert reset_n=0 during a run at cycle 5 → done, busy and steps drop to 0 immediately. A following start re-runs the still-loaded program correctly.
- Assert load during busy → program memory unchanged after the run.

Source files
------------

// File: rtl/fpga_program_runner.sv
// Small program runner for FPGA bring-up tests. It has a loadable program memory and a register file,
// and it runs a MOV/ADD/SUB/JMP/JNZ/HALT ISA with a step budget, fault and timeout reporting.
module fpga_program_runner #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NREGS      = 8,
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned MAX_STEPS  = 255,
  localparam int unsigned RW = $clog2(NREGS),
  localparam int unsigned PW = $clog2(PROG_DEPTH),
  localparam int unsigned SW = $clog2(MAX_STEPS + 1),
  localparam int unsigned IW = 3 + 3 * RW + DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [PW-1:0]         load_addr,
  input  logic [IW-1:0]         load_data,
  input  logic                  start,
  input  logic [RW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic                  timeout,
  output logic [PW-1:0]         ip,
  output logic [SW-1:0]         steps
);

  localparam logic [2:0] OpMov  = 3'd1;
  localparam logic [2:0] OpAdd  = 3'd2;
  localparam logic [2:0] OpSub  = 3'd3;
  localparam logic [2:0] OpJmp  = 3'd4;
  localparam logic [2:0] OpJnz  = 3'd5;
  localparam logic [2:0] OpHalt = 3'd6;
  localparam logic [2:0] OpRsvd = 3'd7;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StDone} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         ip_q, ip_d;
  logic [SW-1:0]         steps_q, steps_d;
  logic                  fault_q, fault_d;
  logic                  timeout_q, timeout_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [IW-1:0]         ir_q, ir_d;

  logic [IW-1:0]         mem_q [PROG_DEPTH];
  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  logic                  load_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  jump;
  logic [PW-1:0]         ip_next;
  logic [PW:0]           ip_inc;
  logic [SW-1:0]         steps_inc;

  logic [2:0]            op;
  logic [RW-1:0]         fd, fa, fb;
  logic [DATA_WIDTH-1:0] imm, ra, rb;

  assign op  = ir_q[IW-1 -: 3];
  assign fd  = ir_q[IW-4 -: RW];
  assign fa  = ir_q[IW-4-RW -: RW];
  assign fb  = ir_q[IW-4-2*RW -: RW];
  assign imm = ir_q[DATA_WIDTH-1:0];
  // r0 is never written, so it reads back as its reset value of zero.
  assign ra  = regs_q[fa];
  assign rb  = regs_q[fb];

  // One extra bit on the incremented ip exposes a run off the end of memory.
  assign ip_inc    = {1'b0, ip_q} + {{PW{1'b0}}, 1'b1};
  assign steps_inc = steps_q + {{(SW-1){1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    ip_d      = ip_q;
    steps_d   = steps_q;
    fault_d   = fault_q;
    timeout_d = timeout_q;
    ir_d      = ir_q;
    load_en   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    jump      = 1'b0;
    ip_next   = ip_inc[PW-1:0];

    unique case (state_q)
      StIdle, StDone: begin
        load_en = load;
        if (start) begin
          state_d   = StFetch;
          ip_d      = '0;
          steps_d   = '0;
          fault_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      StFetch: begin
        ir_d    = mem_q[ip_q];
        state_d = StExec;
      end
      StExec: begin
        steps_d = steps_inc;
        case (op)
          OpMov: begin
            wr_en   = 1'b1;
            wr_data = imm;
          end
          OpAdd: begin
            wr_en   = 1'b1;
            wr_data = ra + rb;
          end
          OpSub: begin
            wr_en   = 1'b1;
            wr_data = ra - rb;
          end
          OpJmp:   jump = 1'b1;
          OpJnz:   jump = (ra != '0);
          default: ;
        endcase
        if (jump) ip_next = imm[PW-1:0];

        if (op == OpHalt) begin
          state_d = StDone;
        end else if (op == OpRsvd) begin
          fault_d = 1'b1;
          state_d = StDone;
        end else if (steps_inc == SW'(MAX_STEPS)) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else if (!jump && ip_inc[PW]) begin
          fault_d = 1'b1;
          state_d = StDone;
        end else begin
          ip_d    = ip_next;
          state_d = StFetch;
        end
      end
    endcase

    if (fd == '0) wr_en = 1'b0;

    busy_d    = (state_d == StFetch) || (state_d == StExec);
    done_d    = (state_d == StDone);
    rd_data_d = (rd_addr == '0) ? '0 : regs_q[rd_addr];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ip_q      <= '0;
      steps_q   <= '0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      ir_q      <= '0;
    end else begin
      state_q   <= state_d;
      ip_q      <= ip_d;
      steps_q   <= steps_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      ir_q      <= ir_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[fd] <= wr_data;
    end
  end

  // Program memory deliberately has no reset so a loaded program survives reset_n.
  always_ff @(posedge clock) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign fault   = fault_q;
  assign timeout = timeout_q;
  assign ip      = ip_q;
  assign steps   = steps_q;

endmodule
